// File: rtl/sad_min_engine.sv
// Sum-of-absolute-differences engine with running-minimum tracking for big/small block candidates.
// Optional early termination of losing candidates is enabled by defining SAD_EARLY_TERM_EN.
module sad_min_engine #(
    parameter int PIX_W       = 8,
    parameter int LANES       = 4,
    parameter int BIG_BEATS   = 16,
    parameter int SMALL_BEATS = 4,
    parameter int SAD_W       = 32,
    parameter int IDX_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   mode,
    input  logic                   clear_min,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PIX_W-1:0] pix_a,
    input  logic [LANES*PIX_W-1:0] pix_b,
    output logic                   busy,
    output logic                   sad_valid,
    output logic [SAD_W-1:0]       sad_out,
    output logic                   sad_sat,
    output logic [SAD_W-1:0]       min_sad,
    output logic [IDX_W-1:0]       min_idx,
    output logic [IDX_W-1:0]       cand_idx
);

    localparam int LSUM_W = PIX_W + $clog2(LANES);
    localparam int MAX_B  = (BIG_BEATS > SMALL_BEATS) ? BIG_BEATS : SMALL_BEATS;
    localparam int CNT_W  = (MAX_B > 1) ? $clog2(MAX_B) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        CMP   = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [SAD_W-1:0]   acc_q;
    logic               sat_q;
    logic               in_ready_q;
    logic               busy_q;
    logic               sad_valid_q;
    logic [SAD_W-1:0]   sad_out_q;
    logic               sad_sat_q;
    logic [SAD_W-1:0]   min_sad_q;
    logic [IDX_W-1:0]   min_idx_q;
    logic [IDX_W-1:0]   cand_idx_q;

    logic [LSUM_W-1:0]  beat_sum;
    logic [SAD_W:0]     acc_sum;
    logic [SAD_W-1:0]   acc_d;
    logic               sat_d;
    logic               freeze;

    function automatic logic [LSUM_W-1:0] beat_sad(input logic [LANES*PIX_W-1:0] a,
                                                   input logic [LANES*PIX_W-1:0] b);
        logic [LSUM_W-1:0] s;
        logic [PIX_W-1:0]  pa;
        logic [PIX_W-1:0]  pb;
        s = '0;
        for (int i = 0; i < LANES; i++) begin
            pa = a[i*PIX_W +: PIX_W];
            pb = b[i*PIX_W +: PIX_W];
            s  = s + LSUM_W'((pa > pb) ? (pa - pb) : (pb - pa));
        end
        return s;
    endfunction

    assign beat_sum = beat_sad(pix_a, pix_b);
    assign acc_sum  = {1'b0, acc_q} + (SAD_W+1)'(beat_sum);

    // A carry out of the accumulator pins it at all ones and marks the result saturated.
    assign acc_d = acc_sum[SAD_W] ? '1 : acc_sum[SAD_W-1:0];
    assign sat_d = sat_q | acc_sum[SAD_W];

`ifdef SAD_EARLY_TERM_EN
    assign freeze = (acc_q >= min_sad_q);
`else
    assign freeze = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            sad_valid_q <= 1'b0;
            sad_out_q   <= '0;
            sad_sat_q   <= 1'b0;
            min_sad_q   <= '1;
            min_idx_q   <= '0;
            cand_idx_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear_min) begin
                        min_sad_q  <= '1;
                        min_idx_q  <= '0;
                        cand_idx_q <= '0;
                    end
                    if (start) begin
                        acc_q      <= '0;
                        sat_q      <= 1'b0;
                        cnt_q      <= mode ? CNT_W'(SMALL_BEATS - 1) : CNT_W'(BIG_BEATS - 1);
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        if (!freeze) begin
                            acc_q <= acc_d;
                            sat_q <= sat_d;
                        end
                        if (cnt_q == '0) begin
                            sad_out_q   <= freeze ? acc_q : acc_d;
                            sad_sat_q   <= freeze ? sat_q : sat_d;
                            sad_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= CMP;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                CMP: begin
                    // Strict compare: ties keep the earlier candidate.
                    if (sad_out_q < min_sad_q) begin
                        min_sad_q <= sad_out_q;
                        min_idx_q <= cand_idx_q;
                    end
                    cand_idx_q  <= cand_idx_q + 1'b1;
                    sad_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                    sad_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign sad_valid = sad_valid_q;
    assign sad_out   = sad_out_q;
    assign sad_sat   = sad_sat_q;
    assign min_sad   = min_sad_q;
    assign min_idx   = min_idx_q;
    assign cand_idx  = cand_idx_q;

endmodule
